pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h1c000000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 npc  input  32  next-PC candidate from the next-PC unit: pc+4, or jump target when jump_taken=1.
REQ-005 jump_taken  input  1  redirect from ID; SHALL be honoured only when stall=0.
REQ-006 stall  input  1  IF/ID hold from the hazard unit.
REQ-007 pc  output  32  current fetch PC; feeds the next-PC unit's if_pc.
REQ-008 inst_req  output  1  instruction-memory request valid.
REQ-009 inst_addr  output  32  request address; SHALL equal pc.
REQ-010 inst_addr_ok  input  1  request accepted.
REQ-011 inst_data_ok  input  1  read data valid.
REQ-012 inst_rdata  input  32  read data.
REQ-013 if_valid  output  1  instruction presented to IF/ID.
REQ-014 if_inst  output  32  instruction presented to IF/ID.
REQ-015 if_flush  output  1  IF/ID SHALL insert a bubble; equals jump_taken & ~stall.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT and HOLD, with at most one outstanding fetch.
REQ-017 IDLE: inst_req=0, if_valid=0; SHALL go to REQ on the next edge.
REQ-018 REQ: inst_req=1. On inst_addr_ok -> WAIT. On redirect without addr_ok: pc<=npc, stay in REQ (address may change because no handshake has completed).
REQ-019 REQ with redirect and addr_ok in the same cycle: SHALL go to WAIT with discard=1 and target<=npc.
REQ-020 WAIT, redirect without data_ok: discard<=1, target<=npc; a later redirect SHALL overwrite target.
REQ-021 WAIT, data_ok with discard=1: data dropped, if_valid=0, pc<=target, discard<=0 -> REQ.
REQ-022 WAIT, data_ok with discard=0 and redirect in the same cycle: data dropped, pc<=npc -> REQ.
REQ-023 WAIT, data_ok with discard=0, no redirect, stall=0: if_valid=1 and if_inst=inst_rdata combinationally in that cycle; pc<=npc -> REQ.
REQ-024 WAIT, data_ok with discard=0 and stall=1: if_valid=1, if_inst=inst_rdata; hold buffer<=inst_rdata -> HOLD.
REQ-025 HOLD: if_valid=1, if_inst=hold buffer. On stall=0 and no redirect: pc<=npc -> REQ. On redirect: buffer invalidated, pc<=npc -> REQ with if_valid=0 in that cycle.
REQ-026 if_valid SHALL be 0 in every case not listed; if_inst is don't-care when if_valid=0.
REQ-027 inst_data_ok or inst_addr_ok received in IDLE or HOLD SHALL be ignored.
REQ-028 pc SHALL change only as stated above; arithmetic wraps modulo 2^32, and pc+4 is formed outside this block.
REQ-029 Steady-state throughput SHALL be one instruction per 2 cycles when addr_ok is asserted in REQ and data_ok arrives the next cycle.

Reset
REQ-030 On rst=1, immediately: state=IDLE, pc=RESET_PC, discard=0, target=0, hold buffer=0, inst_req=0, if_valid=0, if_flush=0, if_inst=0.
REQ-031 Reset asserted during WAIT SHALL abandon the outstanding fetch; its late data_ok is dropped per REQ-027.

Structure
REQ-032 State encodings and the RESET_PC default SHALL live in the shared defines header alongside the NPC_* opcodes.
REQ-033 No sub-module; the next-PC unit SHALL remain instantiated by the parent, fed pc from this block.

Verification
REQ-034 Release rst: cycle 1 inst_req=0; cycle 2 inst_req=1, inst_addr=0x1c000000.
REQ-035 addr_ok in REQ, data_ok next cycle with 0x02800421 and npc=0x1c000004 -> if_valid=1, if_inst=0x02800421 that cycle; next inst_addr=0x1c000004.
REQ-036 data_ok with stall=1 held 3 cycles -> if_valid=1 with the same if_inst for 3+ cycles, pc unchanged, then advance to npc.
REQ-037 jump_taken=1 with npc=0x1c000100 in WAIT, data_ok 2 cycles later -> if_flush=1 for 1 cycle, returned data not presented, next inst_addr=0x1c000100.
REQ-038 jump_taken coincident with data_ok, npc=0x1c000200 -> if_valid=0, next inst_addr=0x1c000200.
REQ-039 rst pulsed mid-WAIT, then data_ok -> all outputs at reset values, data ignored, fetch restarts at 0x1c000000.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: definitions shared by the fetch front end.
//   - Fetch FSM state encodings (also visible on pc_ctrl's dbg_state port).
//   - Default post-reset fetch address.
//   - NPC_* selector opcodes consumed by the next-PC unit in the parent.
package pc_ctrl_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } pc_state_t;

  // Next-PC unit source selectors.
  localparam logic [1:0] NPC_SEQ    = 2'd0; // pc + 4
  localparam logic [1:0] NPC_BRANCH = 2'd1; // pc-relative branch target
  localparam logic [1:0] NPC_JUMP   = 2'd2; // absolute jump target
  localparam logic [1:0] NPC_JUMPR  = 2'd3; // register-indirect target

endpackage

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch PC register and instruction-memory request sequencer.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   npc               next-PC candidate (pc+4 or jump target) from next-PC unit
//   jump_taken        redirect from ID, only acted on while stall=0
//   stall             IF/ID hold from the hazard unit
//   pc                current fetch PC (feeds next-PC unit)
//   inst_req/addr     instruction-memory request; addr always equals pc
//   inst_addr_ok      request accepted
//   inst_data_ok      read data valid, inst_rdata carries it
//   if_valid/if_inst  instruction presented to IF/ID
//   if_flush          IF/ID bubble insert (= effective redirect)
//   dbg_state         current FSM state (pc_state_t encoding)
//
// Handshake: a request is issued while inst_req=1 and is accepted in the
// cycle inst_addr_ok=1; exactly one accepted request is outstanding until
// its inst_data_ok. Data arriving in any state other than WAIT is ignored.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        jump_taken,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        if_flush,
  output logic [1:0]  dbg_state
);

  pc_state_t   r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic        r_discard, w_discard_n;
  logic [31:0] r_target, w_target_n;
  logic [31:0] r_hold_buf, w_hold_buf_n;
  logic        w_redirect;

  assign w_redirect = jump_taken & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_discard  <= 1'b0;
      r_target   <= 32'h0;
      r_hold_buf <= 32'h0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_discard  <= w_discard_n;
      r_target   <= w_target_n;
      r_hold_buf <= w_hold_buf_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_discard_n  = r_discard;
    w_target_n   = r_target;
    w_hold_buf_n = r_hold_buf;
    inst_req     = 1'b0;
    if_valid     = 1'b0;
    if_inst      = 32'h0;

    case (r_state)
      ST_IDLE: begin
        w_state_n = ST_REQ;
      end

      ST_REQ: begin
        inst_req = 1'b1;
        if (inst_addr_ok) begin
          w_state_n = ST_WAIT;
          // Accepted address is now fixed; a same-cycle redirect must
          // throw away the returning word and refetch from the target.
          if (w_redirect) begin
            w_discard_n = 1'b1;
            w_target_n  = npc;
          end
        end else if (w_redirect) begin
          // Nothing accepted yet, so the request address may simply move.
          w_pc_n = npc;
        end
      end

      ST_WAIT: begin
        if (inst_data_ok) begin
          w_state_n = ST_REQ;
          if (r_discard) begin
            w_pc_n      = r_target;
            w_discard_n = 1'b0;
          end else if (w_redirect) begin
            w_pc_n = npc;
          end else begin
            if_valid = 1'b1;
            if_inst  = inst_rdata;
            if (stall) begin
              w_hold_buf_n = inst_rdata;
              w_state_n    = ST_HOLD;
            end else begin
              w_pc_n = npc;
            end
          end
        end else if (w_redirect) begin
          // Later redirects overwrite an earlier pending target.
          w_discard_n = 1'b1;
          w_target_n  = npc;
        end
      end

      ST_HOLD: begin
        if (w_redirect) begin
          w_hold_buf_n = 32'h0;
          w_pc_n       = npc;
          w_state_n    = ST_REQ;
        end else begin
          if_valid = 1'b1;
          if_inst  = r_hold_buf;
          if (!stall) begin
            w_pc_n    = npc;
            w_state_n = ST_REQ;
          end
        end
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign pc        = r_pc;
  assign inst_addr = r_pc;
  // Gated by rst so the flush is low immediately while reset is held.
  assign if_flush  = w_redirect & ~rst;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        jump_taken;
  logic        stall;
  logic [31:0] pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        if_flush;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .npc          (npc),
    .jump_taken   (jump_taken),
    .stall        (stall),
    .pc           (pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_flush     (if_flush),
    .dbg_state    (dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge; inputs change there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic aok, input logic dok, input logic [31:0] rdata,
                       input logic jmp, input logic stl, input logic [31:0] n);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rdata;
    jump_taken   = jmp;
    stall        = stl;
    npc          = n;
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares if_valid against whether a presentation was queued this cycle,
  // and if_inst against the queued word.
  task automatic chk_if(input string tag);
    logic [31:0] e;
    chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".if_inst"}, if_inst, e);
    end
  endtask

  // Request side: state, request valid and address.
  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".inst_req"}, {31'b0, inst_req}, {31'b0, req});
    if (req) chk({tag, ".inst_addr"}, inst_addr, addr);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    total = 0;
    bad = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678);

    // Reset values (jump_taken held high to show flush is masked).
    tick();
    chk("rst.state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    chk("rst.pc", pc, 32'h1c00_0000);
    chk("rst.inst_req", {31'b0, inst_req}, 32'h0);
    chk("rst.if_flush", {31'b0, if_flush}, 32'h0);
    chk("rst.if_inst", if_inst, 32'h0);
    chk_if("rst");

    // Release: cycle 1 no request, cycle 2 request at reset PC.
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_0004);
    chk_req("boot1", 1'b0, 32'h0);
    tick();
    chk_req("boot2", 1'b1, 32'h1c00_0000);

    // Normal fetch: addr_ok then data_ok next cycle, presented same cycle.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_0004);
    chk_if("f0.req");
    tick();
    exp_q.push_back(32'h0280_0421);
    drive(1'b0, 1'b1, 32'h0280_0421, 1'b0, 1'b0, 32'h1c00_0004);
    chk_req("f0.wait", 1'b0, 32'h0);
    chk_if("f0.data");
    tick();
    chk_req("f0.next", 1'b1, 32'h1c00_0004);

    // Stalled delivery: held for 3+ cycles, spurious handshakes ignored.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_0008);
    tick();
    d = $urandom_range(32'h0000_ffff, 32'h0010_0000);
    exp_q.push_back(d);
    drive(1'b0, 1'b1, d, 1'b0, 1'b1, 32'h1c00_0008);
    chk_if("st.data");
    tick();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(d);
      drive(1'b1, 1'b1, ~d, 1'b1, 1'b1, 32'h1c00_0ff0);
      chk("st.state", {30'b0, dbg_state}, {30'b0, ST_HOLD});
      chk("st.pc", pc, 32'h1c00_0004);
      chk("st.flush", {31'b0, if_flush}, 32'h0);
      chk_if("st.hold");
      tick();
    end
    exp_q.push_back(d);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_0008);
    chk_if("st.release");
    tick();
    chk_req("st.next", 1'b1, 32'h1c00_0008);

    // Redirect during WAIT, data two cycles later is dropped.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_000c);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1c00_0100);
    chk("jw.flush1", {31'b0, if_flush}, 32'h1);
    chk_if("jw.c1");
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_000c);
    chk("jw.flush2", {31'b0, if_flush}, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'hdead_beef, 1'b0, 1'b0, 32'h1c00_000c);
    chk_if("jw.drop");
    tick();
    chk_req("jw.next", 1'b1, 32'h1c00_0100);

    // Redirect coincident with data_ok.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_0104);
    tick();
    drive(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h1c00_0200);
    chk_if("jd.drop");
    chk("jd.flush", {31'b0, if_flush}, 32'h1);
    tick();
    chk_req("jd.next", 1'b1, 32'h1c00_0200);

    // Redirect together with addr_ok, and a later WAIT redirect overwrites target.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1c00_0300);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1c00_0380);
    tick();
    drive(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h1c00_0204);
    chk_if("ja.drop");
    tick();
    chk_req("ja.next", 1'b1, 32'h1c00_0380);

    // Redirect in REQ without addr_ok moves the request address.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1c00_0400);
    tick();
    chk_req("jr.next", 1'b1, 32'h1c00_0400);

    // Redirect while holding: bubble in that cycle, refetch from target.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_0404);
    tick();
    exp_q.push_back(32'h3333_3333);
    drive(1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'h1c00_0404);
    chk_if("jh.data");
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1c00_0500);
    chk_if("jh.kill");
    chk("jh.flush", {31'b0, if_flush}, 32'h1);
    tick();
    chk_req("jh.next", 1'b1, 32'h1c00_0500);

    // Reset pulsed mid-WAIT; late data_ok ignored; restart at reset PC.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_0504);
    tick();
    chk("rw.state", {30'b0, dbg_state}, {30'b0, ST_WAIT});
    rst = 1'b1;
    #1;
    chk("rw.pc", pc, 32'h1c00_0000);
    chk("rw.state0", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    chk_req("rw.req", 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h1c00_0004);
    chk_if("rw.late");
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1c00_0004);
    chk_req("rw.restart", 1'b1, 32'h1c00_0000);

    chk("sb.empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
